// File: rtl/micro_seq_pkg.sv
// Shared constants, types and the micro-step table for micro_sequencer.
package micro_seq_pkg;

  localparam int unsigned NUM_OPC         = 15;
  localparam int unsigned BASE_CTRL_W     = 13;
  localparam int unsigned TRAP_BIT        = BASE_CTRL_W - 1;
  localparam int unsigned MAX_TABLE_STEPS = 3;
  localparam int unsigned HALT_OPC        = 13;

  typedef logic [BASE_CTRL_W-1:0] ctrl_word_t;

  typedef enum logic {IDLE, EXEC} state_e;

  // Unused trailing slots are zero; the halt entry repeats its first word up to MAX_STEPS.
  localparam ctrl_word_t STEP_WORD [NUM_OPC][MAX_TABLE_STEPS] = '{
    '{13'd6,    13'd0,    13'd0},
    '{13'd1,    13'd0,    13'd0},
    '{13'd130,  13'd128,  13'd0},
    '{13'd2,    13'd0,    13'd0},
    '{13'd14,   13'd0,    13'd0},
    '{13'd298,  13'd0,    13'd0},
    '{13'd554,  13'd0,    13'd0},
    '{13'd810,  13'd0,    13'd0},
    '{13'd1066, 13'd0,    13'd0},
    '{13'd1322, 13'd0,    13'd0},
    '{13'd1610, 13'd0,    13'd0},
    '{13'd1866, 13'd0,    13'd0},
    '{13'd2058, 13'd0,    13'd0},
    '{13'd4096, 13'd0,    13'd0},
    '{13'd2320, 13'd2320, 13'd16}
  };

  localparam int unsigned STEP_CNT [NUM_OPC] = '{1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3};

endpackage

// File: rtl/micro_rom.sv
// Combinational (opcode, step) -> (control word, last, illegal) lookup.
// MICRO_SEQUENCER_ILLEGAL_TRAP_EN: illegal opcodes emit a trap word and flag illegal.
module micro_rom
  import micro_seq_pkg::*;
#(
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned CTRL_W    = 13,
  parameter int unsigned MAX_STEPS = 4,
  parameter int unsigned STEP_W    = 2
) (
  input  logic [OPC_W-1:0]  opc,
  input  logic [STEP_W-1:0] step,
  output logic [CTRL_W-1:0] word,
  output logic              last,
  output logic              illegal
);

  logic [3:0]  idx;
  int unsigned s;
  int unsigned cnt;

  always_comb begin
    word    = '0;
    last    = 1'b1;
    illegal = 1'b0;
    idx     = opc[3:0];
    s       = 32'(step);
    cnt     = 1;
    if (opc >= OPC_W'(NUM_OPC)) begin
`ifdef MICRO_SEQUENCER_ILLEGAL_TRAP_EN
      word[CTRL_W-1] = 1'b1;
      illegal        = 1'b1;
`endif
    end else if (idx == 4'(HALT_OPC)) begin
      word = CTRL_W'(STEP_WORD[HALT_OPC][0]);
      last = (s == MAX_STEPS - 1);
    end else begin
      // Entries longer than MAX_STEPS are truncated.
      cnt = (STEP_CNT[idx] < MAX_STEPS) ? STEP_CNT[idx] : MAX_STEPS;
      if (s < MAX_TABLE_STEPS) begin
        word = CTRL_W'(STEP_WORD[idx][s[1:0]]);
      end
      last = (s == cnt - 1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Expands accepted opcodes into a stream of control words under back-pressure.
// MICRO_SEQUENCER_ILLEGAL_TRAP_EN (in micro_rom) enables the illegal-opcode trap word.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned CTRL_W    = 13,
  parameter int unsigned MAX_STEPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  opc,
  input  logic              opc_valid,
  output logic              opc_ready,
  input  logic              flush,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic              ctrl_last,
  output logic              illegal
);

  localparam int unsigned STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OPC_W-1:0]   opc_q, opc_d;

  logic [CTRL_W-1:0]  rom_word;
  logic               rom_last;
  logic               rom_illegal;
  logic               exec;

  micro_rom #(
    .OPC_W     (OPC_W),
    .CTRL_W    (CTRL_W),
    .MAX_STEPS (MAX_STEPS),
    .STEP_W    (STEP_W)
  ) u_rom (
    .opc     (opc_q),
    .step    (step_q),
    .word    (rom_word),
    .last    (rom_last),
    .illegal (rom_illegal)
  );

  always_comb begin
    exec       = (state_q == EXEC);
    ctrl_valid = exec;
    ctrl       = exec ? rom_word : '0;
    ctrl_last  = exec & rom_last;
    illegal    = exec & rom_illegal;
    // Combinational from ctrl_ready so the next opcode follows the last step with no bubble.
    opc_ready  = ~flush & (~exec | (ctrl_last & ctrl_ready));

    state_d = state_q;
    step_d  = step_q;
    opc_d   = opc_q;
    if (flush) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (opc_valid && opc_ready) begin
      state_d = EXEC;
      step_d  = '0;
      opc_d   = opc;
    end else if (exec && ctrl_ready) begin
      if (ctrl_last) begin
        state_d = IDLE;
        step_d  = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      opc_q   <= opc_d;
    end
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised, multi-cycle successor to the single-cycle main decoder.
- Accepts opcodes over a valid/ready handshake and expands each one into 1..MAX_STEPS control words.
- Control words are issued one per accepted cycle under downstream back-pressure.
- Sits between instruction fetch and the datapath control inputs.

Parameters:
- OPC_W, 5: opcode width; must be >= 5. Opcodes >= 15 are illegal.
- CTRL_W, 13: control-word width; must be >= 13. Table words are zero-extended to CTRL_W.
- MAX_STEPS, 4: maximum micro-steps per opcode. Step counter width is $clog2(MAX_STEPS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opc  in  OPC_W  opcode from fetch.
- opc_valid  in  1  opc is valid.
- opc_ready  out  1  sequencer can accept opc this cycle.
- flush  in  1  abort the current sequence (synchronous).
- ctrl  out  CTRL_W  current control word.
- ctrl_valid  out  1  ctrl is meaningful.
- ctrl_ready  in  1  datapath consumes ctrl this cycle; low = stall.
- ctrl_last  out  1  ctrl is the final step of its opcode.
- illegal  out  1  current opcode is illegal (always 0 unless ILLEGAL_TRAP_EN).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, step=0, opcode register=0.
  - Outputs: ctrl=0, ctrl_valid=0, ctrl_last=0, illegal=0.
  - opc_ready=1 in the first cycle after reset is released.
- States:
  - IDLE: opc_ready=1, ctrl_valid=0, ctrl=0.
  - EXEC: ctrl_valid=1; ctrl = TABLE[opcode][step].
- Accept: opc_valid & opc_ready on a rising edge latches opc, sets step=0 and enters EXEC.
  - Latency: opcode accepted at edge N gives its first word valid in cycle N+1.
- Advance in EXEC:
  - ctrl_valid & ctrl_ready & !ctrl_last: step increments.
  - ctrl_ready=0: ctrl, step and ctrl_last hold unchanged for any number of cycles.
- ctrl_last = (step == STEPS[opcode]-1).
- opc_ready = (state==IDLE) | (state==EXEC & ctrl_last & ctrl_ready). Combinational from ctrl_ready; no registered path.
- Last step consumed:
  - If opc_valid is high the same cycle: the new opcode is latched and the sequencer stays in EXEC with step=0. Back-to-back with no bubble.
  - Otherwise: return to IDLE.
- flush:
  - Priority: reset > flush > accept/advance.
  - Effect: next state is IDLE, step=0, and opc_valid is ignored that cycle (opc_ready=0 while flush=1).
  - flush in IDLE is a no-op.
- Legal opcode table (step words, STEPS):
  - 0:6, 1:1, 3:2, 4:14, 5:298, 6:554, 7:810, 8:1066, 9:1322, 10:1610, 11:1866, 12:2058: each 1 step.
  - 2: 130,128 (2 steps).
  - 13: 4096, repeating 4096 (halt; STEPS=MAX_STEPS and ctrl_last on the final step).
  - 14: 2320,2320,16 (3 steps).
- Illegal opcode (>=14 excluding 14 itself, i.e. 15..2^OPC_W-1): 1 step, word 0.
- MAX_STEPS smaller than a table entry's step count: that entry is truncated to MAX_STEPS steps.

Optional Feature:
- Macro: MICRO_SEQUENCER_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode emits the 1-step word TRAP_WORD = (1<<(CTRL_W-1)) instead of 0.
  - illegal=1 while that word is valid; illegal clears when the sequencer leaves that opcode.
- Undefined:
  - illegal is tied to 0.
  - Illegal opcodes emit 0 for one step.

Decomposition:
- Package micro_seq_pkg holds:
  - constants NUM_OPC=15, BASE_CTRL_W=13, TRAP_BIT;
  - typedef ctrl_word_t (logic [BASE_CTRL_W-1:0]);
  - typedef state_e {IDLE, EXEC};
  - constant arrays STEP_WORD[15][MAX_TABLE_STEPS] and STEP_CNT[15].
- One sub-module, micro_rom: combinational (opcode, step) -> (word, last, illegal). The FSM and handshake stay in micro_sequencer.

Test Plan:
1. Reset with clk running: assert reset 3 cycles with opc_valid=1 -> ctrl_valid=0, ctrl=0, opc_ready=1 after release; nothing accepted during reset.
2. Opcode 5, ctrl_ready=1 -> one cycle ctrl=298 with ctrl_last=1; then idle. Opcode 14 -> 2320,2320,16 on consecutive cycles, ctrl_last only on 16.
3. Opcode 2 with ctrl_ready=0 for 4 cycles on step 0 -> ctrl holds 130 for 5 cycles, then 128 with ctrl_last=1.
4. Back-to-back: opcodes 1, 2, 0 streamed with opc_valid=1 and ctrl_ready=1 -> ctrl sequence 1,130,128,6 with no ctrl_valid gap; opc_ready is high exactly on the last-step cycles.
5. flush during step 1 of opcode 14 while opc_valid=1 (opc=3) -> next cycle ctrl_valid=0 and opcode 3 is not accepted; it is accepted the following cycle and emits 2.
6. Opcode 20 (OPC_W=5) -> with macro: ctrl=4096 (CTRL_W=13), illegal=1 for 1 cycle. Without macro: ctrl=0, illegal=0, ctrl_last=1.
